// File: rtl/display_game_ctrl.sv
// rtl/display_game_ctrl.sv - game mode FSM, BCD countdown timer and score, display holder sequencing
// Holders are registered from next-state values so every input shows up one cycle later.
module display_game_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int GAME_SECS = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       userquit,
  input  logic       match_pulse,
  input  logic [9:0] led_mask,
  output logic       ingameOn,
  output logic       gameOver,
  output logic [3:0] hex0hldr,
  output logic [3:0] hex2hldr,
  output logic [3:0] hex3hldr,
  output logic [3:0] hex4hldr,
  output logic [3:0] hex5hldr,
  output logic [9:0] ledrhldr
);

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]     INIT_TENS = 4'(GAME_SECS / 10);
  localparam logic [3:0]     INIT_ONES = 4'(GAME_SECS % 10);
  localparam logic [3:0]     BLANK     = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t        r_state, w_state;
  logic [3:0]    r_tmr_t, r_tmr_o, r_scr_t, r_scr_o;
  logic [3:0]    w_tmr_t, w_tmr_o, w_scr_t, w_scr_o;
  logic [PW-1:0] r_presc, w_presc;
  logic          r_blink, w_blink;
  logic          w_tick;
  logic          w_fresh;

  always_comb begin
    w_tick  = (r_state != S_IDLE) && (r_presc == PRESC_MAX);
    w_fresh = start && (r_state != S_PLAY);
    w_state = r_state;
    w_tmr_t = r_tmr_t;
    w_tmr_o = r_tmr_o;
    w_scr_t = r_scr_t;
    w_scr_o = r_scr_o;
    w_blink = r_blink;
    w_presc = (r_state == S_IDLE || w_tick) ? '0 : r_presc + PW'(1);

    // userquit outranks start; both reload every counter
    if (userquit || w_fresh) begin
      w_state = userquit ? S_IDLE : S_PLAY;
      w_tmr_t = INIT_TENS;
      w_tmr_o = INIT_ONES;
      w_scr_t = 4'd0;
      w_scr_o = 4'd0;
      w_presc = '0;
      w_blink = 1'b0;
    end else begin
      case (r_state)
        S_PLAY: begin
          if (match_pulse && !(r_scr_t == 4'd9 && r_scr_o == 4'd9)) begin
            if (r_scr_o == 4'd9) begin
              w_scr_o = 4'd0;
              w_scr_t = r_scr_t + 4'd1;
            end else begin
              w_scr_o = r_scr_o + 4'd1;
            end
          end
          if (w_tick) begin
            if (r_tmr_t == 4'd0 && r_tmr_o == 4'd1) begin
              w_tmr_o = 4'd0;
              w_state = S_OVER;
              w_presc = '0;
              w_blink = 1'b0;
            end else if (r_tmr_o == 4'd0) begin
              w_tmr_o = 4'd9;
              w_tmr_t = r_tmr_t - 4'd1;
            end else begin
              w_tmr_o = r_tmr_o - 4'd1;
            end
          end
        end
        S_OVER: begin
          if (w_tick) w_blink = ~r_blink;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_tmr_t  <= INIT_TENS;
      r_tmr_o  <= INIT_ONES;
      r_scr_t  <= 4'd0;
      r_scr_o  <= 4'd0;
      r_presc  <= '0;
      r_blink  <= 1'b0;
      ingameOn <= 1'b0;
      gameOver <= 1'b0;
      hex0hldr <= BLANK;
      hex2hldr <= BLANK;
      hex3hldr <= BLANK;
      hex4hldr <= BLANK;
      hex5hldr <= BLANK;
      ledrhldr <= 10'd0;
    end else begin
      r_state <= w_state;
      r_tmr_t <= w_tmr_t;
      r_tmr_o <= w_tmr_o;
      r_scr_t <= w_scr_t;
      r_scr_o <= w_scr_o;
      r_presc <= w_presc;
      r_blink <= w_blink;
      case (w_state)
        S_PLAY: begin
          ingameOn <= 1'b1;
          gameOver <= 1'b0;
          hex0hldr <= 4'd1;
          hex2hldr <= w_scr_o;
          hex3hldr <= w_scr_t;
          hex4hldr <= w_tmr_o;
          hex5hldr <= w_tmr_t;
          ledrhldr <= led_mask;
        end
        S_OVER: begin
          ingameOn <= 1'b0;
          gameOver <= 1'b1;
          hex0hldr <= 4'd2;
          hex2hldr <= BLANK;
          hex3hldr <= BLANK;
          hex4hldr <= w_scr_o;
          hex5hldr <= w_scr_t;
          ledrhldr <= {10{w_blink}};
        end
        default: begin
          ingameOn <= 1'b0;
          gameOver <= 1'b0;
          hex0hldr <= 4'd0;
          hex2hldr <= BLANK;
          hex3hldr <= BLANK;
          hex4hldr <= BLANK;
          hex5hldr <= BLANK;
          ledrhldr <= 10'd0;
        end
      endcase
    end
  end

endmodule
